level_meter_peak_hold: RTL
==========================

Name: level_meter_peak_hold

Overview:
- Downstream consumer of per-section min/max pairs produced by the section min/max collector.
- Converts each pair to a log-scaled bar level, about 6 dB per segment.
- Maintains a peak-hold marker that decays after a hold period.
- Drives LED/bar display logic: one accepted pair yields one display update.

Parameters:
- width, 16: sample width; inputs are unsigned offset-binary, midpoint 2^(width-1).
- segments, 15: bar segment count; range 1..width-1.
- hold_sections, 4: sections the peak is held before decay starts; ≥1.
- decay_sections, 2: sections per one-segment peak decrement once decaying; ≥1.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-low (0 = reset).
- i_valid  in  1  min/max pair valid.
- i_ready  out  1  block can accept a pair.
- i_min_value  in  width  section minimum.
- i_max_value  in  width  section maximum.
- o_bar  out  segments  thermometer code; o_bar[k]=1 iff k < level.
- o_peak  out  segments  one-hot peak marker; bit peak-1 set if peak>0, else all 0.
- o_peak_level  out  $clog2(segments+1)  peak index, 0..segments.
- o_update  out  1  one-cycle pulse when o_bar/o_peak change.

Behaviour:
- Synchronous active-low reset on clk:
  - State = S_IDLE; i_ready=1 in the first cycle after reset deasserts.
  - o_bar=0, o_peak=0, o_peak_level=0, o_update=0.
  - Hold and decay counters = 0.
- Reset mid-operation aborts any in-flight pair; no o_update is issued for it.
- FSM states S_IDLE, S_AMP, S_LEVEL, S_UPDATE:
  - S_IDLE: i_ready=1. On i_valid, capture min/max and go to S_AMP; otherwise stay.
  - S_AMP: i_ready=0. Compute and register amplitude.
    - pos = max ≥ C ? max−C : 0, where C = 2^(width-1).
    - neg = min < C ? C−1−min : 0.
    - amp = max(pos, neg), width-1 bits, no overflow possible.
  - S_LEVEL: i_ready=0.
    - bitlen = index of highest set bit of amp, plus 1 (0 if amp=0).
    - level = bitlen − (width−1−segments) if positive, else 0.
  - S_UPDATE: i_ready=0. Apply the display/peak update below, then go to S_IDLE.
- Timing: acceptance edge = edge 0. New o_bar/o_peak/o_peak_level are visible after edge 3, with o_update high for exactly that cycle. i_ready returns to 1 in the same cycle.
- Throughput: one pair per 4 cycles; i_ready is low for 3 cycles per pair.
- Input values are sampled only at the acceptance edge; later changes are ignored.
- Display/peak update in S_UPDATE:
  - o_bar ← thermometer(level).
  - If level ≥ peak: peak←level, hold_cnt←0, decay_cnt←0. This includes equal level, which refreshes the hold.
  - Else if hold_cnt < hold_sections: hold_cnt←hold_cnt+1.
  - Else if decay_cnt == decay_sections−1: peak←peak−1, decay_cnt←0. Peak never drops below level, since level<peak in this branch.
  - Else decay_cnt←decay_cnt+1.
  - Peak at 0 with level 0 takes the first branch: no change, counters cleared.
- Counters saturate by construction; no wrap-around.
- The hold/decay counter width is sized from the max of hold_sections and decay_sections.

Test Plan (width=16, segments=15, hold_sections=4, decay_sections=2):
- Reset low 2 cycles, then high: o_bar=0, o_peak=0, o_update=0, i_ready=1 in the first post-reset cycle.
- Silence, min=max=0x8000: accepted at edge 0; o_update pulse after edge 3. o_bar=0, o_peak_level=0; i_ready low exactly 3 cycles.
- min=0x7F00, max=0x8100:
  - amp=0x0100, level 9.
  - o_bar=0x01FF, o_peak=0x0100, o_peak_level=9.
  - i_valid held high with new data during busy cycles: ignored, no extra o_update.
- Full scale, min=0x0000, max=0xFFFF: amp=0x7FFF, level 15; o_bar=0x7FFF, o_peak_level=15.
- After full scale, feed 8 silence sections:
  - o_peak_level = 15 through section 5.
  - 14 at section 6, 14 at section 7, 13 at section 8.
  - o_bar=0 throughout.
  - Then a level-9 section leaves peak 13; a level-14 section sets peak 14 and restarts the hold.
- Reset pulled low for 1 cycle during S_AMP:
  - No o_update pulse is issued.
  - After release: o_bar=0, o_peak_level=0, i_ready=1.
  - The next pair is processed normally with 3-cycle latency.

Source files
------------

// File: rtl/level_meter_peak_hold.sv
// Level meter with peak hold: turns one section min/max pair into a log-scaled
// thermometer bar plus a one-hot peak marker that holds, then decays.
module level_meter_peak_hold #(
  parameter int unsigned width          = 16,
  parameter int unsigned segments       = 15,
  parameter int unsigned hold_sections  = 4,
  parameter int unsigned decay_sections = 2
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             i_valid,
  output logic                             i_ready,
  input  logic [width-1:0]                 i_min_value,
  input  logic [width-1:0]                 i_max_value,
  output logic [segments-1:0]              o_bar,
  output logic [segments-1:0]              o_peak,
  output logic [$clog2(segments+1)-1:0]    o_peak_level,
  output logic                             o_update
);

  localparam int unsigned LW     = $clog2(segments + 1);
  localparam int unsigned OFF    = width - 1 - segments;
  localparam int unsigned HD_MAX = (hold_sections > decay_sections) ? hold_sections : decay_sections;
  localparam int unsigned CW     = $clog2(HD_MAX + 1);

  localparam logic [CW-1:0] HOLD_C     = CW'(hold_sections);
  localparam logic [CW-1:0] DECAY_LAST = CW'(decay_sections - 1);

  typedef enum logic [1:0] {S_IDLE, S_AMP, S_LEVEL, S_UPDATE} state_t;

  state_t              r_state, w_state_next;
  logic [width-1:0]    r_min, r_max;
  logic [width-2:0]    r_amp, w_pos, w_neg;
  logic [LW-1:0]       r_level, w_level, r_peak;
  logic [CW-1:0]       r_hold, r_decay;
  logic [segments-1:0] r_bar, w_therm;
  logic                r_update;
  int unsigned         w_bitlen;

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state and handshake: one pair walks IDLE->AMP->LEVEL->UPDATE->IDLE.
  always_comb begin
    w_state_next = r_state;
    i_ready      = 1'b0;
    case (r_state)
      S_IDLE: begin
        i_ready = 1'b1;
        if (i_valid) w_state_next = S_AMP;
      end
      S_AMP:    w_state_next = S_LEVEL;
      S_LEVEL:  w_state_next = S_UPDATE;
      S_UPDATE: w_state_next = S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  // Amplitude halves: offset from midpoint above and below, as width-1 bit magnitudes.
  always_comb begin
    w_pos = r_max[width-1] ? r_max[width-2:0] : '0;
    w_neg = r_min[width-1] ? '0 : ~r_min[width-2:0];
  end

  // Bit length of the amplitude mapped onto the segment range.
  always_comb begin
    w_bitlen = 0;
    for (int unsigned i = 0; i < width - 1; i++) begin
      if (r_amp[i]) w_bitlen = i + 1;
    end
    w_level = '0;
    if (w_bitlen > OFF) w_level = LW'(w_bitlen - OFF);
  end

  // Thermometer of the registered level.
  always_comb begin
    w_therm = ~({segments{1'b1}} << r_level);
  end

  // Datapath: capture, amplitude, level, then display and peak-hold update.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_min    <= '0;
      r_max    <= '0;
      r_amp    <= '0;
      r_level  <= '0;
      r_peak   <= '0;
      r_hold   <= '0;
      r_decay  <= '0;
      r_bar    <= '0;
      r_update <= 1'b0;
    end else begin
      r_update <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_valid) begin
            r_min <= i_min_value;
            r_max <= i_max_value;
          end
        end
        S_AMP:   r_amp   <= (w_pos > w_neg) ? w_pos : w_neg;
        S_LEVEL: r_level <= w_level;
        S_UPDATE: begin
          r_bar    <= w_therm;
          r_update <= 1'b1;
          if (r_level >= r_peak) begin
            r_peak  <= r_level;
            r_hold  <= '0;
            r_decay <= '0;
          end else if (r_hold < HOLD_C) begin
            r_hold <= r_hold + 1'b1;
          end else if (r_decay == DECAY_LAST) begin
            r_peak  <= r_peak - 1'b1;
            r_decay <= '0;
          end else begin
            r_decay <= r_decay + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_bar        = r_bar;
  assign o_peak_level = r_peak;
  assign o_peak       = (r_peak == '0) ? '0 : (segments'(1) << (r_peak - 1'b1));
  assign o_update     = r_update;

endmodule
